// File: rtl/morse_keyer_queue.sv
// Queues ASCII bytes and keys them as Morse on o_tone; first mark 3 cycles after the write into an idle, empty queue.
// Backpressure: o_ready drops when the queue is full; bytes offered while full are dropped and o_overflow latches.
module morse_keyer_queue #(
   parameter int DEPTH       = 16,
   parameter int UNIT_CYCLES = 720000,
   parameter int DASH_UNITS  = 3,
   parameter int LETTER_GAP  = 3,
   parameter int WORD_GAP    = 7
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] i_data,
   input  logic       i_valid,
   output logic       o_ready,
   output logic       o_tone,
   output logic       o_busy,
   output logic       o_empty,
   output logic       o_full,
   output logic       o_overflow,
   output logic       o_bad_char
);

   localparam int AW    = $clog2(DEPTH);
   localparam int MAXU  = (DASH_UNITS > WORD_GAP) ? DASH_UNITS : WORD_GAP;
   localparam int CW    = $clog2(MAXU * UNIT_CYCLES + 1);

   localparam logic [CW-1:0] DOT_LEN  = CW'(UNIT_CYCLES - 1);
   localparam logic [CW-1:0] DASH_LEN = CW'(DASH_UNITS * UNIT_CYCLES - 1);
   localparam logic [CW-1:0] LGAP_LEN = CW'(LETTER_GAP * UNIT_CYCLES - 1);
   localparam logic [CW-1:0] WGAP_LEN = CW'((WORD_GAP - LETTER_GAP) * UNIT_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, LOAD, MARK, SPACE, GAP} state_t;

   state_t        state;
   logic [AW:0]   wptr, rptr;
   logic [7:0]    mem [DEPTH];
   logic [7:0]    ch;
   logic [4:0]    bits;
   logic [2:0]    rem;
   logic [CW-1:0] cnt;
   logic          full, empty, push, pop;
   logic [7:0]    code;
   logic [2:0]    code_len;
   logic [4:0]    code_pat, code_aligned;

   assign empty      = (wptr == rptr);
   assign full       = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign o_empty    = empty;
   assign o_full     = full;
   assign o_ready    = !full;
   assign push       = i_valid && !full;
   assign pop        = (state == IDLE) && !empty;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wptr       <= '0;
         rptr       <= '0;
         o_overflow <= 1'b0;
      end else begin
         if (push)
            wptr <= wptr + (AW+1)'(1);
         if (pop)
            rptr <= rptr + (AW+1)'(1);
         if (i_valid && full)
            o_overflow <= 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (push)
         mem[wptr[AW-1:0]] <= i_data;
   end

   // Returns {len, pattern}; pattern is right-aligned, first element in bit len-1, 1 = dash. len 0 = no encoding.
   function automatic logic [7:0] encode(input logic [7:0] c);
      logic [7:0] u;
      logic [7:0] r;
      u = c;
      if (c >= 8'h61 && c <= 8'h7A)
         u = c - 8'h20;
      case (u)
         8'h41: r = {3'd2, 5'b00001};  8'h42: r = {3'd4, 5'b01000};
         8'h43: r = {3'd4, 5'b01010};  8'h44: r = {3'd3, 5'b00100};
         8'h45: r = {3'd1, 5'b00000};  8'h46: r = {3'd4, 5'b00010};
         8'h47: r = {3'd3, 5'b00110};  8'h48: r = {3'd4, 5'b00000};
         8'h49: r = {3'd2, 5'b00000};  8'h4A: r = {3'd4, 5'b00111};
         8'h4B: r = {3'd3, 5'b00101};  8'h4C: r = {3'd4, 5'b00100};
         8'h4D: r = {3'd2, 5'b00011};  8'h4E: r = {3'd2, 5'b00010};
         8'h4F: r = {3'd3, 5'b00111};  8'h50: r = {3'd4, 5'b00110};
         8'h51: r = {3'd4, 5'b01101};  8'h52: r = {3'd3, 5'b00010};
         8'h53: r = {3'd3, 5'b00000};  8'h54: r = {3'd1, 5'b00001};
         8'h55: r = {3'd3, 5'b00001};  8'h56: r = {3'd4, 5'b00001};
         8'h57: r = {3'd3, 5'b00011};  8'h58: r = {3'd4, 5'b01001};
         8'h59: r = {3'd4, 5'b01011};  8'h5A: r = {3'd4, 5'b01100};
         8'h30: r = {3'd5, 5'b11111};  8'h31: r = {3'd5, 5'b01111};
         8'h32: r = {3'd5, 5'b00111};  8'h33: r = {3'd5, 5'b00011};
         8'h34: r = {3'd5, 5'b00001};  8'h35: r = {3'd5, 5'b00000};
         8'h36: r = {3'd5, 5'b10000};  8'h37: r = {3'd5, 5'b11000};
         8'h38: r = {3'd5, 5'b11100};  8'h39: r = {3'd5, 5'b11110};
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   assign code         = encode(ch);
   assign code_len     = code[7:5];
   assign code_pat     = code[4:0];
   assign code_aligned = code_pat << (3'd5 - code_len);

   // Outputs trail the state by one register stage, so durations match the state durations exactly.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= IDLE;
         ch         <= 8'h00;
         bits       <= '0;
         rem        <= '0;
         cnt        <= '0;
         o_tone     <= 1'b0;
         o_busy     <= 1'b0;
         o_bad_char <= 1'b0;
      end else begin
         o_tone     <= (state == MARK);
         o_busy     <= (state != IDLE);
         o_bad_char <= 1'b0;
         case (state)
            IDLE: begin
               if (!empty) begin
                  ch    <= mem[rptr[AW-1:0]];
                  state <= LOAD;
               end
            end
            LOAD: begin
               if (ch == 8'h20) begin
                  cnt   <= WGAP_LEN;
                  state <= GAP;
               end else if (code_len == 3'd0) begin
                  o_bad_char <= 1'b1;
                  state      <= IDLE;
               end else begin
                  bits  <= code_aligned;
                  rem   <= code_len;
                  cnt   <= code_aligned[4] ? DASH_LEN : DOT_LEN;
                  state <= MARK;
               end
            end
            MARK: begin
               if (cnt != '0) begin
                  cnt <= cnt - CW'(1);
               end else if (rem == 3'd1) begin
                  cnt   <= LGAP_LEN;
                  state <= GAP;
               end else begin
                  bits  <= bits << 1;
                  rem   <= rem - 3'd1;
                  cnt   <= DOT_LEN;
                  state <= SPACE;
               end
            end
            SPACE: begin
               if (cnt != '0) begin
                  cnt <= cnt - CW'(1);
               end else begin
                  cnt   <= bits[4] ? DASH_LEN : DOT_LEN;
                  state <= MARK;
               end
            end
            GAP: begin
               if (cnt != '0)
                  cnt <= cnt - CW'(1);
               else
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_morse_keyer_queue.sv
// Directed bench for morse_keyer_queue with UNIT_CYCLES=4, DEPTH=4: tone run lengths, queue flags, bad chars, reset.
module tb_morse_keyer_queue;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] data;
   logic       valid;
   logic       ready, tone, busy, empty, full, ovf, bad;

   int total = 0;
   int bad_n = 0;

   always #5 clk = ~clk;

   morse_keyer_queue #(.DEPTH(4), .UNIT_CYCLES(4)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_data     (data),
      .i_valid    (valid),
      .o_ready    (ready),
      .o_tone     (tone),
      .o_busy     (busy),
      .o_empty    (empty),
      .o_full     (full),
      .o_overflow (ovf),
      .o_bad_char (bad)
   );

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad_n++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Called at a negedge; the byte is written at the following posedge.
   task automatic push(input logic [7:0] b);
      data  = b;
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
   endtask

   // Counts consecutive samples with tone at lvl; stops on the first differing sample.
   task automatic run(input logic lvl, output int n);
      n = 0;
      while (tone === lvl && n < 300) begin
         n++;
         @(negedge clk);
      end
   endtask

   // Counts silent busy samples until busy drops.
   task automatic quiet(output int n);
      n = 0;
      while (busy === 1'b1 && tone === 1'b0 && n < 300) begin
         n++;
         @(negedge clk);
      end
   endtask

   int n, nb;
   int hi [6] = '{4, 12, 4, 4, 12, 12};
   int lo [5] = '{14, 14, 4, 14, 4};
   logic [7:0] ab [2] = '{8'h61, 8'h41};

   initial begin
      rst   = 1'b1;
      valid = 1'b0;
      data  = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_tone",  tone,  0);
      check("rst_busy",  busy,  0);
      check("rst_empty", empty, 1);
      check("rst_full",  full,  0);
      check("rst_ready", ready, 1);
      check("rst_ovf",   ovf,   0);
      check("rst_bad",   bad,   0);
      @(negedge clk);

      // 'E': 3 low samples, 4 high, 12 silent, then idle.
      push(8'h45);
      run(1'b0, n); check("e_latency", n, 3);
      run(1'b1, n); check("e_mark", n, 4);
      quiet(n);     check("e_gap", n, 12);
      check("e_busy", busy, 0);
      check("e_empty", empty, 1);

      // 'a' and 'A' key the same: dot, space, dash, letter gap.
      for (int i = 0; i < 2; i++) begin
         push(ab[i]);
         run(1'b0, n); check("a_latency", n, 3);
         run(1'b1, n); check("a_dot", n, 4);
         run(1'b0, n); check("a_space", n, 4);
         run(1'b1, n); check("a_dash", n, 12);
         quiet(n);     check("a_gap", n, 12);
      end

      // "E E": two pushes already elapsed, so 1 low sample remains before the first mark.
      push(8'h45); push(8'h20); push(8'h45);
      run(1'b0, n); check("ee_latency", n, 1);
      run(1'b1, n); check("ee_mark1", n, 4);
      run(1'b0, n); check("ee_word_gap", n, 12 + 2 + 16 + 2);
      run(1'b1, n); check("ee_mark2", n, 4);
      quiet(n);     check("ee_gap", n, 12);

      // Fill the queue while 'T' is keying; the fifth byte is dropped.
      push(8'h54);
      run(1'b0, n); check("t_latency", n, 3);
      push(8'h45); push(8'h54); push(8'h49); push(8'h4D);
      check("q_full", full, 1);
      check("q_ready", ready, 0);
      check("q_ovf_before", ovf, 0);
      push(8'h41);
      check("q_ovf_after", ovf, 1);
      check("q_full_after", full, 1);
      run(1'b1, n); check("t_mark_rest", n, 7);
      run(1'b0, n); check("t_gap", n, 14);
      for (int i = 0; i < 6; i++) begin
         run(1'b1, n); check($sformatf("q_hi%0d", i), n, hi[i]);
         if (i < 5) begin
            run(1'b0, n); check($sformatf("q_lo%0d", i), n, lo[i]);
         end
      end
      quiet(n); check("q_gap", n, 12);
      check("q_empty", empty, 1);
      check("q_ovf_sticky", ovf, 1);

      // '#' is discarded with one bad_char pulse and no gap; 'E' follows directly.
      push(8'h23); push(8'h45);
      n = 0; nb = 0;
      while (tone !== 1'b1 && n < 100) begin
         if (bad === 1'b1) nb++;
         n++;
         @(negedge clk);
      end
      check("bad_pulses", nb, 1);
      check("bad_latency", n, 4);
      run(1'b1, n); check("bad_e_mark", n, 4);
      quiet(n);     check("bad_e_gap", n, 12);

      // Reset during the dash of 'T' with another byte queued.
      push(8'h54);
      run(1'b0, n); check("r_latency", n, 3);
      push(8'h45);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("r_tone",  tone,  0);
      check("r_empty", empty, 1);
      check("r_busy",  busy,  0);
      check("r_ovf",   ovf,   0);
      repeat (20) @(negedge clk);
      check("r_still_quiet", tone | busy, 0);
      push(8'h45);
      run(1'b0, n); check("r_e_latency", n, 3);
      run(1'b1, n); check("r_e_mark", n, 4);
      quiet(n);     check("r_e_gap", n, 12);

      $display("test done: total=%0d bad=%0d", total, bad_n);
      $finish;
   end

endmodule
